// File: rtl/button_debounce.sv
// button_debounce
//   Conditions a raw, bouncing, active-low push-button into a clean
//   active-low level for the downstream lockout stage. A level change is
//   accepted only after it has been sampled on DEBOUNCE_CYCLES+1
//   consecutive rising edges. A change that reverses before then is
//   counted as a rejected bounce.
//
//   State | Meaning
//   ------+----------------------------------------------
//   REL   | released, btn_db = 1
//   PWAIT | qualifying a press, btn_db = 1, settling = 1
//   PRS   | pressed, btn_db = 0
//   RWAIT | qualifying a release, btn_db = 0, settling = 1
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset
//   btn_raw    in   raw button pin, active-low (0 = pressed)
//   btn_db     out  debounced level, active-low, registered
//   settling   out  1 while a candidate level change is being qualified
//   bounce_cnt out  saturating count of aborted qualifications
//
// Build option:
//   DEBOUNCE_SYNC_EN - when defined, btn_raw passes through a 2-flop
//   synchroniser (reset to 1) before the FSM, adding 2 cycles of latency.
//   When undefined, btn_raw must already be synchronous to clk.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int BOUNCE_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_raw,
  output logic                btn_db,
  output logic                settling,
  output logic [BOUNCE_W-1:0] bounce_cnt
);

  typedef enum logic [1:0] {
    REL   = 2'd0,
    PWAIT = 2'd1,
    PRS   = 2'd2,
    RWAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = btn_raw;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                btn_db_q, btn_db_d;
  logic                settling_q, settling_d;
  logic [BOUNCE_W-1:0] bounce_q, bounce_d;
  logic                bounce_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= REL;
      cnt_q      <= '0;
      btn_db_q   <= 1'b1;
      settling_q <= 1'b0;
      bounce_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_db_q   <= btn_db_d;
      settling_q <= settling_d;
      bounce_q   <= bounce_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    btn_db_d   = btn_db_q;
    bounce_inc = 1'b0;
    case (state_q)
      REL: begin
        if (!s) begin
          state_d = PWAIT;
          cnt_d   = '0;
        end
      end
      PWAIT: begin
        // A reversal wins over the terminal count.
        if (s) begin
          state_d    = REL;
          cnt_d      = '0;
          bounce_inc = 1'b1;
        end else if (cnt_q == CNT_TC) begin
          state_d  = PRS;
          btn_db_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRS: begin
        if (s) begin
          state_d = RWAIT;
          cnt_d   = '0;
        end
      end
      RWAIT: begin
        if (!s) begin
          state_d    = PRS;
          cnt_d      = '0;
          bounce_inc = 1'b1;
        end else if (cnt_q == CNT_TC) begin
          state_d  = REL;
          btn_db_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = REL;
        btn_db_d = 1'b1;
        cnt_d    = '0;
      end
    endcase

    settling_d = (state_d == PWAIT) || (state_d == RWAIT);
    bounce_d   = (bounce_inc && (bounce_q != '1)) ? bounce_q + BOUNCE_W'(1) : bounce_q;
  end

  assign btn_db     = btn_db_q;
  assign settling   = settling_q;
  assign bounce_cnt = bounce_q;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int N        = 4;
  localparam int BOUNCE_W = 8;
  localparam int BMAX     = (1 << BOUNCE_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                btn_raw = 1'b1;
  logic                btn_db;
  logic                settling;
  logic [BOUNCE_W-1:0] bounce_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: tracks how long the sampled input has differed from
  // the accepted level; acceptance after N+1 samples, early return = bounce.
  int m_db, m_pend, m_run, m_bounce, m_settle;
  int m_p0, m_p1;

  button_debounce #(.DEBOUNCE_CYCLES(N), .CNT_W(19), .BOUNCE_W(BOUNCE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_db     (btn_db),
    .settling   (settling),
    .bounce_cnt (bounce_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input int raw, input int rstn);
    int s;
    if (rstn == 0) begin
      m_db = 1; m_pend = 0; m_run = 0; m_bounce = 0; m_settle = 0;
      m_p0 = 1; m_p1 = 1;
      return;
    end
`ifdef DEBOUNCE_SYNC_EN
    s    = m_p1;
    m_p1 = m_p0;
    m_p0 = raw;
`else
    s = raw;
`endif
    if (s == m_db) begin
      if (m_pend != 0 && m_bounce < BMAX) m_bounce++;
      m_pend = 0;
    end else begin
      m_run  = (m_pend != 0) ? m_run + 1 : 1;
      m_pend = 1;
      if (m_run == N + 1) begin
        m_db   = s;
        m_pend = 0;
      end
    end
    m_settle = m_pend;
  endtask

  task automatic drive(input int raw, input int rstn);
    @(negedge clk);
    btn_raw = raw[0];
    rst_n   = rstn[0];
    @(posedge clk);
    model_edge(raw, rstn);
    #1;
    chk("btn_db", int'(btn_db), m_db);
    chk("settling", int'(settling), m_settle);
    chk("bounce_cnt", int'(bounce_cnt), m_bounce);
  endtask

  initial begin
    int lvl, len;
    model_edge(1, 0);

    // reset and idle
    drive(1, 0);
    chk("rst_btn_db", int'(btn_db), 1);
    chk("rst_settling", int'(settling), 0);
    chk("rst_bounce", int'(bounce_cnt), 0);
    repeat (20) drive(1, 1);

    // clean press, then exactly-N-edge bounce pulses to saturation
    repeat (10) drive(0, 1);
    repeat (10) drive(1, 1);
    repeat (300) begin
      repeat (N) drive(0, 1);
      drive(1, 1);
    end
    repeat (4) drive(1, 1);
    chk("bounce_sat", int'(bounce_cnt), BMAX);
    chk("bounce_sat_db", int'(btn_db), 1);

    // reset, press, release with a bounce
    drive(1, 0);
    chk("rst2_bounce", int'(bounce_cnt), 0);
    repeat (10) drive(0, 1);
    repeat (2) drive(1, 1);
    drive(0, 1);
    repeat (10) drive(1, 1);

    // reset mid-press, held button must re-qualify
    repeat (10) drive(0, 1);
    drive(0, 0);
    chk("midpress_rst_db", int'(btn_db), 1);
    repeat (10) drive(0, 1);
    chk("midpress_requal_db", int'(btn_db), 0);

    // randomized runs of random length, occasional resets
    lvl = 1;
    repeat (600) begin
      lvl = 1 - lvl;
      len = $urandom_range(1, N + 4);
      repeat (len) drive(lvl, ($urandom_range(0, 99) < 2) ? 0 : 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
